// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and rounding helper for the rotation-mode CORDIC.
// Angles are Q16.16 degrees; x/y datapath is 32-bit signed with 8 fractional bits.
package cordic_pkg;

  localparam int ITER_DEF  = 16;
  localparam int DW        = 32;
  localparam int FRAC_BITS = 8;

  localparam logic signed [DW-1:0] RND_HALF = 32'sd128;
  localparam logic [15:0]          K_Q15    = 16'd19898;

  localparam logic [31:0] Q90  = 32'd5898240;
  localparam logic [31:0] Q180 = 32'd11796480;
  localparam logic [31:0] Q270 = 32'd17694720;
  localparam logic [31:0] Q360 = 32'd23592960;
  localparam logic [31:0] Q720 = 32'd47185920;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ROT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Round a Q8 value to integer and clamp it into the signed 16-bit range.
  function automatic logic signed [15:0] round_sat(input logic signed [DW-1:0] v);
    logic signed [DW:0]  s;
    logic signed [15:0]  res;
    s = $signed({v[DW-1], v}) + $signed({RND_HALF[DW-1], RND_HALF});
    s = s >>> FRAC_BITS;
    if (s > 33'sd32767) begin
      res = 16'sh7FFF;
    end else if (s < -33'sd32768) begin
      res = 16'sh8000;
    end else begin
      res = s[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cordic_angle_rom.sv
// atan(2^-i) in Q16.16 degrees, one entry per micro-rotation; read by both the
// rotation and vectoring CORDIC blocks.
module cordic_angle_rom (
  input  logic [4:0]  addr_i,
  output logic [21:0] atan_o
);

  // Table lookup; indices past the last useful step read as zero.
  always_comb begin
    case (addr_i)
      5'd0:    atan_o = 22'd2949120;
      5'd1:    atan_o = 22'd1740967;
      5'd2:    atan_o = 22'd919879;
      5'd3:    atan_o = 22'd466945;
      5'd4:    atan_o = 22'd234379;
      5'd5:    atan_o = 22'd117304;
      5'd6:    atan_o = 22'd58666;
      5'd7:    atan_o = 22'd29335;
      5'd8:    atan_o = 22'd14668;
      5'd9:    atan_o = 22'd7334;
      5'd10:   atan_o = 22'd3667;
      5'd11:   atan_o = 22'd1833;
      5'd12:   atan_o = 22'd917;
      5'd13:   atan_o = 22'd458;
      5'd14:   atan_o = 22'd229;
      5'd15:   atan_o = 22'd115;
      5'd16:   atan_o = 22'd57;
      5'd17:   atan_o = 22'd29;
      5'd18:   atan_o = 22'd14;
      5'd19:   atan_o = 22'd7;
      5'd20:   atan_o = 22'd4;
      5'd21:   atan_o = 22'd2;
      default: atan_o = 22'd0;
    endcase
  end

endmodule

// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC: (r, theta) -> (r cos theta, r sin theta), one
// request in flight, fixed latency, registered valid/ready outputs.
module cordic_rotate
  import cordic_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] r_in,
  input  logic [31:0]        theta_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] x_out,
  output logic signed [15:0] y_out,
  output logic               err
);

  localparam logic [4:0] ITER_L = 5'(ITER);

  state_e                 state_q, state_d;
  logic signed [15:0]     r_q, r_d;
  logic [31:0]            theta_q, theta_d;
  logic signed [DW-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic [1:0]             quad_q, quad_d;
  logic [4:0]             i_q, i_d;
  logic                   err_q, err_d;
  logic                   out_valid_q, out_valid_d;
  logic                   err_out_q, err_out_d;
  logic signed [15:0]     x_out_q, x_out_d, y_out_q, y_out_d;

  logic [31:0]            theta_w_s, qoff_s;
  logic [1:0]             quad_s;
  logic signed [DW-1:0]   prod_s, x_sh_s, y_sh_s, atan_ext_s, x_un_s, y_un_s;
  logic [21:0]            atan_s;

  cordic_angle_rom u_angle_rom (
    .addr_i (i_q),
    .atan_o (atan_s)
  );

  assign prod_s     = $signed({{16{r_q[15]}}, r_q}) * $signed({16'd0, K_Q15});
  assign x_sh_s     = x_q >>> i_q;
  assign y_sh_s     = y_q >>> i_q;
  assign atan_ext_s = $signed({10'd0, atan_s});

  // Fold the angle into [0, 360) and split off the quadrant.
  always_comb begin
    theta_w_s = (theta_q >= Q360) ? (theta_q - Q360) : theta_q;
    if (theta_w_s < Q90) begin
      quad_s = 2'd0;
      qoff_s = 32'd0;
    end else if (theta_w_s < Q180) begin
      quad_s = 2'd1;
      qoff_s = Q90;
    end else if (theta_w_s < Q270) begin
      quad_s = 2'd2;
      qoff_s = Q180;
    end else begin
      quad_s = 2'd3;
      qoff_s = Q270;
    end
  end

  // Map the first-quadrant result back to the original quadrant.
  always_comb begin
    case (quad_q)
      2'd0:    begin x_un_s = x_q;   y_un_s = y_q;   end
      2'd1:    begin x_un_s = -y_q;  y_un_s = x_q;   end
      2'd2:    begin x_un_s = -x_q;  y_un_s = -y_q;  end
      2'd3:    begin x_un_s = y_q;   y_un_s = -x_q;  end
      default: begin x_un_s = x_q;   y_un_s = y_q;   end
    endcase
  end

  // Next-state logic for the control FSM and the rotation datapath.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    theta_d     = theta_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    quad_d      = quad_q;
    i_d         = i_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    err_out_d   = err_out_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          r_d     = r_in;
          theta_d = theta_in;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        x_d     = prod_s >>> 7;
        y_d     = 32'sd0;
        z_d     = $signed(theta_w_s - qoff_s);
        quad_d  = quad_s;
        err_d   = (theta_q >= Q720);
        i_d     = 5'd0;
        state_d = ST_ROT;
      end
      ST_ROT: begin
        // The extra cycle at i == ITER lets the output stage start from registered x/y.
        if (i_q == ITER_L) begin
          x_out_d     = round_sat(x_un_s);
          y_out_d     = round_sat(y_un_s);
          err_out_d   = err_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (!z_q[DW-1]) begin
          x_d = x_q - y_sh_s;
          y_d = y_q + x_sh_s;
          z_d = z_q - atan_ext_s;
          i_d = i_q + 5'd1;
        end else begin
          x_d = x_q + y_sh_s;
          y_d = y_q - x_sh_s;
          z_d = z_q + atan_ext_s;
          i_d = i_q + 5'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      r_q         <= 16'sd0;
      theta_q     <= 32'd0;
      x_q         <= 32'sd0;
      y_q         <= 32'sd0;
      z_q         <= 32'sd0;
      quad_q      <= 2'd0;
      i_q         <= 5'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      err_out_q   <= 1'b0;
      x_out_q     <= 16'sd0;
      y_out_q     <= 16'sd0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      theta_q     <= theta_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      quad_q      <= quad_d;
      i_q         <= i_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      err_out_q   <= err_out_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign err       = err_out_q;

endmodule

// File: tb/tb_cordic_rotate.sv
// Self-checking bench for cordic_rotate: directed vector table, backpressure and
// reset sequences, and random vectors against a floating-point polar model.
module tb_cordic_rotate;

  localparam real PI = 3.14159265358979323846;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] r_in;
  logic [31:0]        theta_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;
  logic               err;

  int n_chk;
  int n_fail;

  cordic_rotate #(.ITER(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .theta_in  (theta_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [31:0] th;
    int          ex;
    int          ey;
    logic        eerr;
    bit          chkxy;
  } vec_t;

  function automatic logic [31:0] deg(input int d);
    logic [31:0] t;
    t = d;
    return t << 16;
  endfunction

  // Reference: exact polar-to-cartesian conversion, rounded and clamped to 16 bits.
  function automatic int ref_xy(input int r, input logic [31:0] th, input bit is_y);
    real a;
    real v;
    int  q;
    a = (real'(th) / 65536.0) * PI / 180.0;
    v = real'(r) * (is_y ? $sin(a) : $cos(a));
    if (v > 32767.0) v = 32767.0;
    if (v < -32768.0) v = -32768.0;
    q = int'(v);
    return q;
  endfunction

  task automatic chk(input string nm, input int act, input int exp, input int tol);
    n_chk++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  task automatic do_req(input int r, input logic [31:0] th, output int xo, output int yo,
                        output logic eo, output int lat);
    int w;
    @(negedge clk);
    r_in      = 16'(r);
    theta_in  = th;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("accept_timeout", w, 0, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    xo = int'(x_out);
    yo = int'(y_out);
    eo = err;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    int          xo, yo, lat, w;
    logic        eo;
    int          rr;
    logic [31:0] th;
    real         ang, diff;

    n_chk = 0;
    n_fail = 0;

    vecs[0]  = '{10000, deg(0),   10000,  0,      1'b0, 1'b1};
    vecs[1]  = '{10000, deg(30),  8660,   5000,   1'b0, 1'b1};
    vecs[2]  = '{10000, deg(90),  0,      10000,  1'b0, 1'b1};
    vecs[3]  = '{10000, deg(225), -7071,  -7071,  1'b0, 1'b1};
    vecs[4]  = '{10000, deg(300), 5000,   -8660,  1'b0, 1'b1};
    vecs[5]  = '{-32768, deg(180), 32767, 0,      1'b0, 1'b1};
    vecs[6]  = '{1000,  deg(400), 766,    643,    1'b0, 1'b1};
    vecs[7]  = '{1000,  deg(40),  766,    643,    1'b0, 1'b1};
    vecs[8]  = '{10000, deg(360), 10000,  0,      1'b0, 1'b1};
    vecs[9]  = '{1000,  deg(720), 0,      0,      1'b1, 1'b0};
    vecs[10] = '{10000, deg(270), 0,      -10000, 1'b0, 1'b1};
    vecs[11] = '{10000, deg(180), -10000, 0,      1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    r_in      = 16'sd0;
    theta_in  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  int'(in_ready),  1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_x",         int'(x_out),     0, 0);
    chk("rst_y",         int'(y_out),     0, 0);
    chk("rst_err",       int'(err),       0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      do_req(vecs[k].r, vecs[k].th, xo, yo, eo, lat);
      chk($sformatf("vec%0d_latency", k), lat, 18, 0);
      chk($sformatf("vec%0d_err", k), int'(eo), int'(vecs[k].eerr), 0);
      if (vecs[k].chkxy) begin
        chk($sformatf("vec%0d_x", k), xo, vecs[k].ex, 3);
        chk($sformatf("vec%0d_y", k), yo, vecs[k].ey, 3);
      end
      chk($sformatf("vec%0d_ready_after", k), int'(in_ready), 1, 0);
      chk($sformatf("vec%0d_valid_after", k), int'(out_valid), 0, 0);
    end

    // Backpressure with a stray request while busy.
    @(negedge clk);
    r_in = 16'sd10000; theta_in = deg(30); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    r_in = 16'sd1000; theta_in = deg(40); in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_busy_in_ready", int'(in_ready), 0, 0);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp_out_valid_seen", int'(out_valid), 1, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_x", int'(x_out), 8660, 3);
      chk("bp_hold_y", int'(y_out), 5000, 3);
      chk("bp_hold_valid", int'(out_valid), 1, 0);
      chk("bp_hold_in_ready", int'(in_ready), 0, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", int'(in_ready), 1, 0);
    chk("bp_release_valid", int'(out_valid), 0, 0);

    // Reset in the middle of the rotation (i = 7).
    @(negedge clk);
    r_in = 16'sd10000; theta_in = deg(225); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrot_in_ready_busy", int'(in_ready), 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrot_rst_in_ready",  int'(in_ready),  1, 0);
    chk("midrot_rst_out_valid", int'(out_valid), 0, 0);
    chk("midrot_rst_x",         int'(x_out),     0, 0);
    chk("midrot_rst_y",         int'(y_out),     0, 0);
    chk("midrot_rst_err",       int'(err),       0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(10000, deg(300), xo, yo, eo, lat);
    chk("post_rst_latency", lat, 18, 0);
    chk("post_rst_x", xo, 5000, 3);
    chk("post_rst_y", yo, -8660, 3);

    // Random vectors against the polar model, plus angle round trip for large r.
    for (int k = 0; k < 40; k++) begin
      rr = int'($urandom_range(65534, 0)) - 32767;
      if (k % 2 == 0) rr = int'($urandom_range(32767, 16000));
      th = $urandom_range(32'd47185919, 32'd0);
      do_req(rr, th, xo, yo, eo, lat);
      chk("rand_latency", lat, 18, 0);
      chk("rand_err", int'(eo), 0, 0);
      chk($sformatf("rand%0d_x r=%0d th=%0d", k, rr, th), xo, ref_xy(rr, th, 1'b0), 3);
      chk($sformatf("rand%0d_y r=%0d th=%0d", k, rr, th), yo, ref_xy(rr, th, 1'b1), 3);
      if (rr >= 16000) begin
        ang  = $atan2(real'(yo), real'(xo)) * 180.0 / PI;
        diff = ang - real'(th) / 65536.0;
        while (diff > 180.0) diff = diff - 360.0;
        while (diff <= -180.0) diff = diff + 360.0;
        chk($sformatf("rand%0d_roundtrip_mdeg_x10", k), int'(diff * 10000.0), 0, 100);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
